// File: rtl/min_max_ctrl_pkg.sv
// Shared types and encodings for the min_max_top configuration sequencer.
package min_max_ctrl_pkg;

    typedef enum logic [2:0] {
        StTestOn,
        StTestOff,
        StRunStatic,
        StRunSweep,
        StRunLinear
    } state_e;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_SWEEP  = 2'd1;
    localparam logic [1:0] MODE_LINEAR = 2'd2;
    localparam logic [1:0] MODE_TEST   = 2'd3;

    localparam logic [1:0] COM_NORMAL  = 2'b00;
    localparam logic [1:0] COM_LINEAR  = 2'b01;
    localparam logic [1:0] COM_OFF     = 2'b10;
    localparam logic [1:0] COM_ON      = 2'b11;

endpackage

// File: rtl/min_max_clkdiv.sv
// Parametric tick generator: tick_o is high for one cycle every DIV cycles.
module min_max_clkdiv #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/min_max_ctrl.sv
// Sequencer for min_max_top: lamp test after reset, then configurations accepted
// over a valid/ready port (static, sweep, linear), plus the blink oscillator.
module min_max_ctrl
    import min_max_ctrl_pkg::*;
#(
    parameter int unsigned VALSIZE     = 4,
    parameter int unsigned OSC_DIV     = 4,
    parameter int unsigned STEP_DIV    = 8,
    parameter int unsigned TEST_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [1:0]         cfg_mode_i,
    input  logic [VALSIZE-1:0] cfg_min_i,
    input  logic [VALSIZE-1:0] cfg_max_i,
    input  logic [VALSIZE-1:0] cfg_val_i,
    output logic               cfg_err_o,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o
);

    localparam int unsigned TCW = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [TCW-1:0]     test_cnt_q, test_cnt_d;
    logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, val_q, val_d;
    logic [1:0]         com_q, com_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               osc_q;
    logic               osc_tick, step_tick, step_clr;
    logic               xfer, reject, test_done;

    assign xfer      = cfg_valid_i & ready_q;
    assign reject    = ((cfg_mode_i == MODE_STATIC) || (cfg_mode_i == MODE_SWEEP)) &&
                       (cfg_min_i > cfg_max_i);
    assign test_done = (test_cnt_q == TCW'(TEST_CYCLES - 1));
    // Restart the step period on every accepted config so each value lasts STEP_DIV cycles.
    assign step_clr  = (xfer & ~reject) | (state_q != StRunSweep);

    min_max_clkdiv #(
        .DIV (OSC_DIV)
    ) u_osc_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .tick_o (osc_tick)
    );

    min_max_clkdiv #(
        .DIV (STEP_DIV)
    ) u_step_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (step_clr),
        .tick_o (step_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StTestOn;
            test_cnt_q <= '0;
            min_q      <= '0;
            max_q      <= '1;
            val_q      <= '0;
            com_q      <= COM_ON;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            osc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            test_cnt_q <= test_cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            val_q      <= val_d;
            com_q      <= com_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            osc_q      <= osc_q ^ osc_tick;
        end
    end

    always_comb begin
        state_d    = state_q;
        test_cnt_d = test_cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        val_d      = val_q;
        err_d      = 1'b0;

        unique case (state_q)
            StTestOn: begin
                test_cnt_d = test_done ? '0 : test_cnt_q + 1'b1;
                if (test_done) state_d = StTestOff;
            end
            StTestOff: begin
                test_cnt_d = test_done ? '0 : test_cnt_q + 1'b1;
                if (test_done) state_d = StRunStatic;
            end
            StRunSweep: begin
                if (step_tick) val_d = (val_q == max_q) ? min_q : val_q + 1'b1;
            end
            default: ;
        endcase

        // A transfer overrides any sweep step on the same edge; a reject freezes everything.
        if (xfer) begin
            val_d = val_q;
            if (reject) begin
                err_d = 1'b1;
            end else begin
                unique case (cfg_mode_i)
                    MODE_STATIC: begin
                        min_d   = cfg_min_i;
                        max_d   = cfg_max_i;
                        val_d   = cfg_val_i;
                        state_d = StRunStatic;
                    end
                    MODE_SWEEP: begin
                        min_d   = cfg_min_i;
                        max_d   = cfg_max_i;
                        val_d   = cfg_min_i;
                        state_d = StRunSweep;
                    end
                    MODE_LINEAR: begin
                        min_d   = cfg_min_i;
                        max_d   = cfg_max_i;
                        val_d   = cfg_val_i;
                        state_d = StRunLinear;
                    end
                    MODE_TEST: begin
                        test_cnt_d = '0;
                        state_d    = StTestOn;
                    end
                endcase
            end
        end
    end

    // Decoded from next state so com/ready stay registered outputs.
    always_comb begin
        com_d   = COM_ON;
        ready_d = 1'b0;
        unique case (state_d)
            StTestOn:    com_d = COM_ON;
            StTestOff:   com_d = COM_OFF;
            StRunStatic,
            StRunSweep: begin
                com_d   = COM_NORMAL;
                ready_d = 1'b1;
            end
            StRunLinear: begin
                com_d   = COM_LINEAR;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;
    assign com_o       = com_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign val_o       = val_q;
    assign osc_o       = osc_q;

endmodule

// File: tb/tb_min_max_ctrl.sv
// Directed bench for min_max_ctrl: lamp test, oscillator, config handshake and sweep.
module tb_min_max_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [1:0] cfg_mode_i;
    logic [3:0] cfg_min_i;
    logic [3:0] cfg_max_i;
    logic [3:0] cfg_val_i;
    logic       cfg_err_o;
    logic [1:0] com_o;
    logic [3:0] min_o;
    logic [3:0] max_o;
    logic [3:0] val_o;
    logic       osc_o;

    int errors = 0;
    int checks = 0;

    min_max_ctrl #(
        .VALSIZE     (4),
        .OSC_DIV     (4),
        .STEP_DIV    (8),
        .TEST_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_min_i   (cfg_min_i),
        .cfg_max_i   (cfg_max_i),
        .cfg_val_i   (cfg_val_i),
        .cfg_err_o   (cfg_err_o),
        .com_o       (com_o),
        .min_o       (min_o),
        .max_o       (max_o),
        .val_o       (val_o),
        .osc_o       (osc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_cfg(input logic [1:0] mode, input logic [3:0] mn, input logic [3:0] mx,
                            input logic [3:0] v, output int waited);
        waited      = 0;
        cfg_valid_i = 1'b1;
        cfg_mode_i  = mode;
        cfg_min_i   = mn;
        cfg_max_i   = mx;
        cfg_val_i   = v;
        while (!cfg_ready_o && waited < 100) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            errors++;
            $display("FAIL handshake_timeout: ready=%b after %0d cycles, want 1", cfg_ready_o, waited);
        end
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_com;
        rst_ni      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_mode_i  = 2'd0;
        cfg_min_i   = 4'd0;
        cfg_max_i   = 4'd0;
        cfg_val_i   = 4'd0;
        @(negedge clk_i);
        checks++; if (com_o !== 2'b11) begin errors++; $display("FAIL reset_com: got %b want 11", com_o); end
        checks++; if (min_o !== 4'd0) begin errors++; $display("FAIL reset_min: got %0d want 0", min_o); end
        checks++; if (max_o !== 4'd15) begin errors++; $display("FAIL reset_max: got %0d want 15", max_o); end
        checks++; if (val_o !== 4'd0) begin errors++; $display("FAIL reset_val: got %0d want 0", val_o); end
        checks++; if (osc_o !== 1'b0) begin errors++; $display("FAIL reset_osc: got %b want 0", osc_o); end
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cfg_ready_o); end
        checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err_o); end
        rst_ni = 1'b1;
        #1;
        for (int k = 0; k <= 10; k++) begin
            exp_com = (k < 4) ? 2'b11 : (k < 8) ? 2'b10 : 2'b00;
            checks++;
            if (com_o !== exp_com) begin
                errors++; $display("FAIL lamp_com k=%0d: got %b want %b", k, com_o, exp_com);
            end
            checks++;
            if (cfg_ready_o !== (k >= 8)) begin
                errors++; $display("FAIL lamp_ready k=%0d: got %b want %b", k, cfg_ready_o, (k >= 8));
            end
            if (k == 8) begin
                checks++;
                if ({min_o, max_o, val_o} !== {4'd0, 4'd15, 4'd0}) begin
                    errors++; $display("FAIL lamp_cfg: got %0d/%0d/%0d want 0/15/0", min_o, max_o, val_o);
                end
            end
            step();
        end
    endtask

    task automatic test_osc();
        logic exp_osc;
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            exp_osc = ((k / 4) % 2) == 1;
            checks++;
            if (osc_o !== exp_osc) begin
                errors++; $display("FAIL osc k=%0d: got %b want %b", k, osc_o, exp_osc);
            end
            step();
        end
    endtask

    task automatic test_static();
        int w;
        send_cfg(2'd0, 4'd3, 4'd12, 4'd8, w);
        checks++;
        if ({min_o, max_o, val_o} !== {4'd3, 4'd12, 4'd8}) begin
            errors++; $display("FAIL static_cfg: got %0d/%0d/%0d want 3/12/8", min_o, max_o, val_o);
        end
        checks++; if (com_o !== 2'b00) begin errors++; $display("FAIL static_com: got %b want 00", com_o); end
        checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL static_err: got %b want 0", cfg_err_o); end
    endtask

    task automatic test_reject();
        int w;
        send_cfg(2'd0, 4'd10, 4'd2, 4'd5, w);
        checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL reject_err: got %b want 1", cfg_err_o); end
        checks++;
        if ({min_o, max_o, val_o} !== {4'd3, 4'd12, 4'd8}) begin
            errors++; $display("FAIL reject_hold: got %0d/%0d/%0d want 3/12/8", min_o, max_o, val_o);
        end
        step();
        checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL reject_pulse: got %b want 0", cfg_err_o); end
        send_cfg(2'd1, 4'd9, 4'd4, 4'd0, w);
        checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL reject_sweep_err: got %b want 1", cfg_err_o); end
        checks++;
        if ({com_o, val_o} !== {2'b00, 4'd8}) begin
            errors++; $display("FAIL reject_sweep_hold: got com=%b val=%0d want com=00 val=8", com_o, val_o);
        end
        step();
    endtask

    task automatic test_sweep();
        int w;
        logic [3:0] seq [5];
        seq = '{4'd5, 4'd6, 4'd7, 4'd5, 4'd6};
        send_cfg(2'd1, 4'd5, 4'd7, 4'd9, w);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (val_o !== seq[k / 8]) begin
                errors++; $display("FAIL sweep_val k=%0d: got %0d want %0d", k, val_o, seq[k / 8]);
            end
            step();
        end
    endtask

    task automatic test_sweep_equal();
        int w;
        send_cfg(2'd1, 4'd9, 4'd9, 4'd3, w);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (val_o !== 4'd9) begin
                errors++; $display("FAIL sweep_equal k=%0d: got %0d want 9", k, val_o);
            end
            step();
        end
    endtask

    task automatic test_step_collision();
        int w;
        send_cfg(2'd1, 4'd5, 4'd7, 4'd0, w);
        repeat (7) step();
        checks++; if (val_o !== 4'd5) begin errors++; $display("FAIL collide_pre: got %0d want 5", val_o); end
        // This transfer lands on the same edge as the next sweep step.
        send_cfg(2'd0, 4'd1, 4'd14, 4'd2, w);
        checks++;
        if ({min_o, max_o, val_o, com_o} !== {4'd1, 4'd14, 4'd2, 2'b00}) begin
            errors++;
            $display("FAIL collide_cfg: got %0d/%0d/%0d com=%b want 1/14/2 com=00", min_o, max_o, val_o, com_o);
        end
        repeat (10) step();
        checks++; if (val_o !== 4'd2) begin errors++; $display("FAIL collide_static: got %0d want 2", val_o); end
    endtask

    task automatic test_linear();
        int w;
        send_cfg(2'd2, 4'd0, 4'd0, 4'd11, w);
        checks++; if (com_o !== 2'b01) begin errors++; $display("FAIL linear_com: got %b want 01", com_o); end
        checks++;
        if ({min_o, max_o, val_o} !== {4'd0, 4'd0, 4'd11}) begin
            errors++; $display("FAIL linear_cfg: got %0d/%0d/%0d want 0/0/11", min_o, max_o, val_o);
        end
        checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL linear_err: got %b want 0", cfg_err_o); end
    endtask

    task automatic test_holdoff();
        int w;
        send_cfg(2'd3, 4'd0, 4'd0, 4'd0, w);
        checks++;
        if ({com_o, cfg_ready_o} !== {2'b11, 1'b0}) begin
            errors++; $display("FAIL rerun_start: got com=%b ready=%b want com=11 ready=0", com_o, cfg_ready_o);
        end
        checks++; if (val_o !== 4'd11) begin errors++; $display("FAIL rerun_keep_val: got %0d want 11", val_o); end
        send_cfg(2'd0, 4'd2, 4'd13, 4'd6, w);
        checks++; if (w !== 8) begin errors++; $display("FAIL holdoff_wait: got %0d cycles want 8", w); end
        checks++;
        if ({min_o, max_o, val_o, com_o} !== {4'd2, 4'd13, 4'd6, 2'b00}) begin
            errors++;
            $display("FAIL holdoff_cfg: got %0d/%0d/%0d com=%b want 2/13/6 com=00", min_o, max_o, val_o, com_o);
        end
    endtask

    task automatic test_mode3_reset();
        int w;
        logic [1:0] exp_com;
        send_cfg(2'd1, 4'd5, 4'd7, 4'd0, w);
        send_cfg(2'd3, 4'd0, 4'd0, 4'd0, w);
        checks++;
        if ({com_o, cfg_ready_o} !== {2'b11, 1'b0}) begin
            errors++; $display("FAIL m3_start: got com=%b ready=%b want com=11 ready=0", com_o, cfg_ready_o);
        end
        checks++;
        if ({min_o, max_o, val_o} !== {4'd5, 4'd7, 4'd5}) begin
            errors++; $display("FAIL m3_keep: got %0d/%0d/%0d want 5/7/5", min_o, max_o, val_o);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_com = (k < 4) ? 2'b11 : 2'b10;
            checks++;
            if (com_o !== exp_com) begin
                errors++; $display("FAIL m3_com k=%0d: got %b want %b", k, com_o, exp_com);
            end
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({com_o, min_o, max_o, val_o, osc_o, cfg_ready_o, cfg_err_o} !==
            {2'b11, 4'd0, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got com=%b min=%0d max=%0d val=%0d osc=%b ready=%b err=%b want 11/0/15/0/0/0/0",
                     com_o, min_o, max_o, val_o, osc_o, cfg_ready_o, cfg_err_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            exp_com = (k < 4) ? 2'b11 : 2'b10;
            checks++;
            if (com_o !== exp_com) begin
                errors++; $display("FAIL restart_com k=%0d: got %b want %b", k, com_o, exp_com);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_osc();
        test_static();
        test_reject();
        test_sweep();
        test_sweep_equal();
        test_step_collision();
        test_linear();
        test_holdoff();
        test_mode3_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/min_max_ctrl.md
Name: min_max_ctrl

Overview:
Sequencer that drives the configuration inputs of min_max_top (com, min, max, value, osc) from one clocked domain. After reset it runs a power-on lamp test (all ON, then all OFF) and then applies configurations accepted over a valid/ready port. It supports static display, an auto-sweep of the value across [min,max], and linear mode. It also generates the blink oscillator used for the out-of-range LEDs.

Parameters:
VALSIZE, 4, width of min/max/value (display has 2**VALSIZE LEDs)
OSC_DIV, 4, clock cycles between osc_o toggles (>=1)
STEP_DIV, 8, clock cycles between value increments in sweep mode (>=1)
TEST_CYCLES, 4, clock cycles spent in each lamp-test phase (>=1)

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous reset, active-low
cfg_valid_i  in  1  configuration request valid
cfg_ready_o  out  1  controller accepts configuration this cycle
cfg_mode_i  in  2  0=static, 1=sweep, 2=linear, 3=rerun lamp test
cfg_min_i  in  VALSIZE  requested min
cfg_max_i  in  VALSIZE  requested max
cfg_val_i  in  VALSIZE  requested value (static/linear); ignored in sweep
cfg_err_o  out  1  one-cycle pulse: request rejected
com_o  out  2  to min_max_top com_i
min_o  out  VALSIZE  to min_i
max_o  out  VALSIZE  to max_i
val_o  out  VALSIZE  to val_i
osc_o  out  1  to osc_i

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: state=TEST_ON, com_o=2'b11, min_o=0, max_o=all ones, val_o=0, osc_o=0, cfg_ready_o=0, cfg_err_o=0, all counters=0.
- Oscillator:
  - Free-running, independent of state.
  - osc_o toggles when the divider reaches OSC_DIV-1; the divider then wraps to 0.
  - First toggle occurs on the OSC_DIV-th rising edge after reset release.
- FSM states:
  - TEST_ON: com_o=11. After TEST_CYCLES cycles go to TEST_OFF.
  - TEST_OFF: com_o=10. After TEST_CYCLES cycles go to RUN_STATIC, keeping the current min/max/val.
  - RUN_STATIC: com_o=00.
  - RUN_SWEEP: com_o=00.
  - RUN_LINEAR: com_o=01.
  - Test phases last exactly TEST_CYCLES cycles each, measured as com_o cycles observed after reset release.
- Handshake:
  - cfg_ready_o=1 only in the RUN_* states.
  - A transfer occurs on a rising edge with cfg_valid_i & cfg_ready_o.
  - The new outputs are visible the cycle after the transfer (latency 1).
  - Requests while ready=0 are held off, not dropped.
- Accept rules:
  - mode 0: load min/max/val, go to RUN_STATIC. A val outside [min,max] is still accepted (display dark).
  - mode 1: load min/max, set val_o=min, clear step counter, go to RUN_SWEEP.
  - mode 2: load val; min/max are loaded but unused by the DUT; go to RUN_LINEAR.
  - mode 3: go to TEST_ON with the counter cleared; min/max/val are retained.
  - Reject when mode is 0 or 1 and cfg_min_i > cfg_max_i. On reject: cfg_err_o=1 for one cycle; state and outputs are unchanged; the handshake still completes (ready was 1).
- Sweep:
  - Every STEP_DIV cycles val_o increments.
  - When val_o == max_o, the next step loads min_o (wrap); no overflow past all ones.
  - When min == max, val_o stays constant.
- Simultaneous events:
  - An accepted config on the same edge as a sweep step wins; the step is discarded.
  - The oscillator is unaffected by config acceptance.
- Reset mid-operation: all state is lost immediately (asynchronous) and the sequence restarts at TEST_ON.

Decomposition:
- Package min_max_ctrl_pkg holds:
  - the state enum typedef;
  - the mode constants (MODE_STATIC/SWEEP/LINEAR/TEST);
  - the com encodings (COM_NORMAL=00, COM_LINEAR=01, COM_OFF=10, COM_ON=11).
- One sub-module, min_max_clkdiv: a parametric tick generator (DIV param, tick pulse output). It is instantiated twice: once for the oscillator and once for the sweep step (the latter with a synchronous clear).

Test Plan:
- Reset, then release -> com_o=11 for 4 cycles, then 10 for 4 cycles, then 00 with min=0/max=15/val=0; cfg_ready_o=0 until 00.
- Free-run after reset -> osc_o toggles every 4 cycles: first 0→1 at edge 4, then 1→0 at edge 8.
- Static accept min=3, max=12, val=8 -> next cycle min_o=3, max_o=12, val_o=8, com_o=00, cfg_err_o=0.
- Sweep min=5, max=7 -> val_o sequence 5,6,7,5,6 with 8 cycles per value.
- Reject: static min=10, max=2 -> cfg_err_o single-cycle pulse; previous outputs unchanged.
- Mode 3 during sweep, plus rst_ni asserted mid-TEST_OFF -> lamp test restarts at com_o=11; after reset, outputs return to their reset values asynchronously.
